// File: rtl/updown_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : updown_pkg
//  Description : Shared encodings for the up/down counter monitor: event
//                codes, zone states, the packed FIFO entry layout and a
//                saturating helper for the drop counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package updown_pkg;

    // Event codes carried on evt_code
    typedef enum logic [1:0] {
        EVT_WRAP_UP   = 2'd0,
        EVT_WRAP_DOWN = 2'd1,
        EVT_CROSS_HI  = 2'd2,
        EVT_CROSS_LO  = 2'd3
    } evt_code_t;

    // Zone FSM states, also driven directly on the zone output
    typedef enum logic [1:0] {
        ZONE_BELOW  = 2'd0,
        ZONE_INSIDE = 2'd1,
        ZONE_ABOVE  = 2'd2
    } zone_t;

    // One FIFO entry: code in the top two bits, causing sample below
    typedef struct packed {
        evt_code_t   code;
        logic [31:0] value;
    } evt_t;

    localparam int          c_evt_width = 34;
    localparam logic [31:0] c_all_ones  = 32'hFFFF_FFFF;

    // Add 0..2 to an 8-bit count, clamping at 8'hFF
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, a} + {7'd0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage : updown_pkg
`default_nettype wire

// File: rtl/updown_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : updown_monitor_if
//  Description : Bundles the monitor's sample input, event stream handshake
//                and status outputs.
//                  value      : counter sample, consumed every cycle
//                  evt_valid  : event head present
//                  evt_ready  : consumer accepts head
//                  evt_code   : head event code (updown_pkg::evt_code_t)
//                  evt_value  : sample that caused the head event
//                  zone       : current zone (updown_pkg::zone_t)
//                  drop_count : saturating lost-event count
//                master = monitor side, slave = upstream/consumer side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface updown_monitor_if;
    logic [31:0] value;
    logic        evt_valid;
    logic        evt_ready;
    logic [1:0]  evt_code;
    logic [31:0] evt_value;
    logic [1:0]  zone;
    logic [7:0]  drop_count;

    modport master (
        input  value,
        input  evt_ready,
        output evt_valid,
        output evt_code,
        output evt_value,
        output zone,
        output drop_count
    );

    modport slave (
        output value,
        output evt_ready,
        input  evt_valid,
        input  evt_code,
        input  evt_value,
        input  zone,
        input  drop_count
    );
endinterface : updown_monitor_if
`default_nettype wire

// File: rtl/updown_evt_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : updown_evt_fifo
//  Description : Synchronous event FIFO with valid/ready read side.
//                Head is a plain register read (no write-to-read bypass), so
//                an entry written into an empty FIFO appears one cycle later.
//                A write while full is accepted only if the head is popped in
//                the same cycle.
//  Ports       : clock, reset (async, active-high)
//                i_push / i_data  : write request and entry
//                i_ready          : consumer ready; pop = o_valid & i_ready
//                o_valid / o_data : head present / head entry
//                o_full           : all entries occupied
//  Revision    : 1.0 - initial release
// ============================================================================
module updown_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 34
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic             i_ready,
    output logic                  o_valid,
    output logic [WIDTH-1:0]      o_data,
    output logic                  o_full
);

    localparam int c_aw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = c_aw + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_aw-1:0]    r_wptr;
    logic [c_aw-1:0]    r_rptr;
    logic [c_cnt_w-1:0] r_count;

    logic w_rd;
    logic w_wr;

    assign o_valid = (r_count != '0);
    assign o_full  = (r_count == c_cnt_w'(DEPTH));
    assign o_data  = r_mem[r_rptr];

    assign w_rd = o_valid & i_ready;
    // When full, the slot being freed by the pop is the one the write lands in
    assign w_wr = i_push & (~o_full | w_rd);

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    // Memory is cleared on reset so an empty FIFO presents an all-zero head.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : updown_evt_fifo
`default_nettype wire

// File: rtl/updown_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : updown_monitor
//  Description : Watches an up/down counter value. Detects wrap-around
//                (FFFFFFFF<->0) and zone crossings of HI/LO thresholds with
//                exit hysteresis, and queues one event per cycle into an
//                event FIFO. Lost events are counted (saturating).
//                Parameters must satisfy HI_THRESH > LO_THRESH + 2*HYST and
//                FIFO_DEPTH a power of two >= 2.
//  Ports       : clock, reset (async, active-high)
//                bus (updown_monitor_if.master):
//                  value in; evt_valid/evt_ready/evt_code/evt_value stream;
//                  zone and drop_count status out.
//  Revision    : 1.0 - initial release
// ============================================================================
module updown_monitor
    import updown_pkg::*;
#(
    parameter logic [31:0] HI_THRESH  = 32'd1000,
    parameter logic [31:0] LO_THRESH  = 32'd100,
    parameter logic [31:0] HYST       = 32'd8,
    parameter int          FIFO_DEPTH = 4
) (
    input  wire logic         clock,
    input  wire logic         reset,
    updown_monitor_if.master  bus
);

    // Zone exit points: leave ABOVE below c_hi_exit, leave BELOW above c_lo_exit
    localparam logic [31:0] c_hi_exit = HI_THRESH - HYST;
    localparam logic [31:0] c_lo_exit = LO_THRESH + HYST;

    logic [31:0] r_prev;
    logic        r_prev_valid;
    zone_t       r_zone;
    logic [7:0]  r_drop;

    logic        w_wrap_up;
    logic        w_wrap_down;
    logic        w_cross_hi;
    logic        w_cross_lo;
    logic        w_wrap_any;
    logic        w_cross_any;
    logic        w_push;
    evt_code_t   w_code;
    logic        w_suppressed;
    logic        w_full_drop;
    logic [1:0]  w_drop_inc;

    logic                   w_fifo_valid;
    logic                   w_fifo_full;
    logic [c_evt_width-1:0] w_fifo_head;

    // ------------------------------------------------------------------
    // Previous-sample register for wrap detection
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
        end else begin
            r_prev       <= bus.value;
            r_prev_valid <= 1'b1;
        end
    end

    assign w_wrap_up   = r_prev_valid && (r_prev == c_all_ones) && (bus.value == 32'd0);
    assign w_wrap_down = r_prev_valid && (r_prev == 32'd0) && (bus.value == c_all_ones);

    // ------------------------------------------------------------------
    // Zone FSM. Threshold tests override the hysteresis hold, so the only
    // way into ABOVE is value>=HI_THRESH and into BELOW is value<=LO_THRESH.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_zone <= ZONE_BELOW;
        end else if (bus.value >= HI_THRESH) begin
            r_zone <= ZONE_ABOVE;
        end else if (bus.value <= LO_THRESH) begin
            r_zone <= ZONE_BELOW;
        end else begin
            case (r_zone)
                ZONE_ABOVE: if (bus.value < c_hi_exit) r_zone <= ZONE_INSIDE;
                ZONE_BELOW: if (bus.value > c_lo_exit) r_zone <= ZONE_INSIDE;
                default:    r_zone <= ZONE_INSIDE;
            endcase
        end
    end

    // Crossing = entering a threshold zone from any other zone
    assign w_cross_hi = (bus.value >= HI_THRESH) && (r_zone != ZONE_ABOVE);
    assign w_cross_lo = (bus.value <  HI_THRESH) && (bus.value <= LO_THRESH)
                        && (r_zone != ZONE_BELOW);

    // ------------------------------------------------------------------
    // Event selection: wraps win over crossings; at most one of each kind
    // can be active, so a collision costs exactly one dropped event.
    // ------------------------------------------------------------------
    assign w_wrap_any  = w_wrap_up | w_wrap_down;
    assign w_cross_any = w_cross_hi | w_cross_lo;
    assign w_push      = w_wrap_any | w_cross_any;

    always_comb begin
        w_code = EVT_CROSS_LO;
        if (w_wrap_up)        w_code = EVT_WRAP_UP;
        else if (w_wrap_down) w_code = EVT_WRAP_DOWN;
        else if (w_cross_hi)  w_code = EVT_CROSS_HI;
    end

    assign w_suppressed = w_wrap_any & w_cross_any;
    // Full FIFO still takes the push if the head leaves in the same cycle
    assign w_full_drop  = w_push & w_fifo_full & ~(w_fifo_valid & bus.evt_ready);
    assign w_drop_inc   = {1'b0, w_suppressed} + {1'b0, w_full_drop};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_drop <= '0;
        end else begin
            r_drop <= sat_add8(r_drop, w_drop_inc);
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    updown_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_evt_width)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  ({w_code, bus.value}),
        .i_ready (bus.evt_ready),
        .o_valid (w_fifo_valid),
        .o_data  (w_fifo_head),
        .o_full  (w_fifo_full)
    );

    assign bus.evt_valid  = w_fifo_valid;
    assign bus.evt_code   = w_fifo_head[33:32];
    assign bus.evt_value  = w_fifo_head[31:0];
    assign bus.zone       = r_zone;
    assign bus.drop_count = r_drop;

endmodule : updown_monitor
`default_nettype wire

// File: doc/updown_monitor.md
UPDOWN_MONITOR -- requirements
Module: updown_monitor

Interface
REQ-001 SHALL have parameter HI_THRESH, default 32'd1000, upper zone threshold.
REQ-002 SHALL have parameter LO_THRESH, default 32'd100, lower zone threshold; HI_THRESH > LO_THRESH + 2*HYST.
REQ-003 SHALL have parameter HYST, default 32'd8, hysteresis width for zone exit.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, event FIFO entries (power of two, >=2).
REQ-005 clock  input  1  sole clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 value  input  32  counter value from upstream up/down counter, sampled every cycle.
REQ-008 evt_valid  output  1  FIFO head holds an event.
REQ-009 evt_ready  input  1  consumer accepts head when evt_valid & evt_ready.
REQ-010 evt_code  output  2  head event code: 0 WRAP_UP, 1 WRAP_DOWN, 2 CROSS_HI, 3 CROSS_LO.
REQ-011 evt_value  output  32  value sample that caused head event.
REQ-012 zone  output  2  current zone: 0 BELOW, 1 INSIDE, 2 ABOVE.
REQ-013 drop_count  output  8  saturating count of events lost.

Function
REQ-014 SHALL register each value as prev and set prev_valid at every rising edge outside reset.
REQ-015 SHALL detect WRAP_UP when prev_valid, prev==32'hFFFFFFFF, value==0.
REQ-016 SHALL detect WRAP_DOWN when prev_valid, prev==0, value==32'hFFFFFFFF.
REQ-017 SHALL not detect wraps on the first sample after reset (prev_valid=0).
REQ-018 Zone FSM, evaluated each edge on value, in priority order: value>=HI_THRESH -> ABOVE; value<=LO_THRESH -> BELOW; else from ABOVE stay unless value<HI_THRESH-HYST, then INSIDE; from BELOW stay unless value>LO_THRESH+HYST, then INSIDE; INSIDE stays INSIDE.
REQ-019 SHALL raise CROSS_HI on any transition into ABOVE, CROSS_LO on any transition into BELOW; exits to INSIDE raise no event.
REQ-020 SHALL push at most one event per cycle; priority WRAP_* over CROSS_*; a suppressed simultaneous event increments drop_count.
REQ-021 Event pushed at the edge sampling value, visible on evt_* immediately after that edge (1-cycle latency).
REQ-022 FIFO SHALL be first-in first-out; evt_code/evt_value stable while evt_valid & !evt_ready.
REQ-023 Push when full SHALL be discarded and increment drop_count, unless a pop occurs the same cycle, in which case the push is accepted.
REQ-024 Push when empty with evt_ready high SHALL still register; evt_valid rises next cycle (no bypass).
REQ-025 drop_count SHALL saturate at 8'hFF; two drops in one cycle (full plus suppressed) add 2, saturating.
REQ-026 zone output SHALL be the registered FSM state.

Reset
REQ-027 On reset: zone=BELOW, prev_valid=0, prev=0, FIFO empty (evt_valid=0), evt_code=0, evt_value=0, drop_count=0.
REQ-028 Reset mid-operation SHALL discard all queued events immediately and asynchronously.
REQ-029 First edge after reset release SHALL evaluate zone normally but detect no wrap.

Structure
REQ-030 Event code and zone encodings SHALL live in shared package updown_pkg as typedefs/constants.
REQ-031 FIFO SHALL be sub-module updown_evt_fifo (parameterised depth, width 34).
REQ-032 Detection and zone FSM SHALL reside in updown_monitor top.

Verification
REQ-033 Ramp value 0..1000 with evt_ready=1 -> single CROSS_HI with evt_value=1000; zone=ABOVE.
REQ-034 From ABOVE, descend to 993 -> zone ABOVE held at 992+..; at 991 -> INSIDE; no event.
REQ-035 value 32'hFFFFFFFF then 0 -> WRAP_UP event with evt_value=0 and drop_count+1 (CROSS_LO suppressed), zone=BELOW.
REQ-036 evt_ready=0, force 6 events -> 4 queued, drop_count=2; then pop+push same cycle when full -> accepted, drop_count unchanged.
REQ-037 Assert reset with 3 queued events -> evt_valid=0 and drop_count=0 before next edge; first post-reset sample 0 after prev FFFFFFFF -> no WRAP_UP.
REQ-038 Hold evt_ready=0 for 5 cycles with evt_valid=1 -> evt_code/evt_value unchanged.
